// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demultiplexer: each channel has a one-entry holding
// register drained by its own valid/ready handshake; bad selects are counted and dropped.
//
// state | meaning
// EMPTY | channel holds no word, out_valid low
// FULL  | channel holds a word awaiting its consumer
module demux_1xn_stream #(
  parameter int ID        = 1,
  parameter int WIDTH     = 2,
  parameter int N_OUT     = 4,
  parameter int SEL_W     = $clog2(N_OUT),
  parameter int ZERO_IDLE = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_OUT-1:0][WIDTH-1:0] outp,
  output logic [N_OUT-1:0]            out_valid,
  input  logic [N_OUT-1:0]            out_ready,
  output logic [7:0]                  drop_cnt
);

  // Select is widened so the range compare also works when N_OUT == 2**SEL_W.
  localparam int CMP_W = (SEL_W > 7) ? SEL_W + 1 : 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t        state_q [N_OUT];
  ch_state_t        state_d [N_OUT];
  logic [WIDTH-1:0] data_q  [N_OUT];
  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] load;
  logic [CMP_W-1:0] sel_ext;
  logic             sel_in_range;
  logic             accept;

  if (N_OUT < 2 || N_OUT > 64 || SEL_W < $clog2(N_OUT) || ID < 0) begin : g_param_check
    $error("demux_1xn_stream: illegal parameter set");
  end

  assign sel_ext      = CMP_W'(in_sel);
  assign sel_in_range = (sel_ext < CMP_W'(N_OUT));

  always_comb begin
    full    = '0;
    sel_hit = '0;
    for (int i = 0; i < N_OUT; i++) begin
      full[i]    = (state_q[i] == FULL);
      sel_hit[i] = sel_in_range && (sel_ext == CMP_W'(i));
    end
  end

  // Head-of-line: only the addressed channel decides; out-of-range never stalls.
  assign in_ready = !sel_in_range || (|(sel_hit & (~full | out_ready)));
  assign accept   = in_valid && in_ready;
  assign load     = sel_hit & {N_OUT{accept}};

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      state_d[i] = state_q[i];
      if (load[i]) begin
        state_d[i] = FULL;
      end else if (full[i] && out_ready[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_OUT; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        state_q[i] <= state_d[i];
        if (load[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (in_valid && !sel_in_range && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    outp      = '0;
    out_valid = full;
    for (int i = 0; i < N_OUT; i++) begin
      outp[i] = ((ZERO_IDLE != 0) && !full[i]) ? '0 : data_q[i];
    end
  end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench for demux_1xn_stream: a 4-channel instance checked against a
// per-channel holding-slot model, and a 3-channel instance for out-of-range drops.
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [7:0]      in_data4;
  logic [1:0]      in_sel4;
  logic            in_valid4;
  logic            in_ready4;
  logic [3:0][7:0] outp4;
  logic [3:0]      out_valid4;
  logic [3:0]      out_ready4;
  logic [7:0]      drop_cnt4;

  logic [7:0]      in_data3;
  logic [1:0]      in_sel3;
  logic            in_valid3;
  logic            in_ready3;
  logic [2:0][7:0] outp3;
  logic [2:0]      out_valid3;
  logic [2:0]      out_ready3;
  logic [7:0]      drop_cnt3;

  int errors = 0;
  int checks = 0;

  demux_1xn_stream #(.ID(4), .WIDTH(8), .N_OUT(4), .ZERO_IDLE(1)) dut4 (
    .clk(clk), .rstn(rstn), .in_data(in_data4), .in_sel(in_sel4),
    .in_valid(in_valid4), .in_ready(in_ready4), .outp(outp4),
    .out_valid(out_valid4), .out_ready(out_ready4), .drop_cnt(drop_cnt4)
  );

  demux_1xn_stream #(.ID(3), .WIDTH(8), .N_OUT(3), .SEL_W(2), .ZERO_IDLE(1)) dut3 (
    .clk(clk), .rstn(rstn), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .outp(outp3),
    .out_valid(out_valid3), .out_ready(out_ready3), .drop_cnt(drop_cnt3)
  );

  // Reference: each channel is an optional held word.
  logic       m_full [4];
  logic [7:0] m_data [4];
  int         m_drop3;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = 8'h00;
    end
    m_drop3 = 0;
  endfunction

  function automatic logic m_ready(input int sel, input logic [3:0] rdy);
    if (sel >= 4) return 1'b1;
    return !m_full[sel] || rdy[sel];
  endfunction

  function automatic void m_step(input logic v, input int sel, input logic [7:0] d,
                                 input logic [3:0] rdy);
    logic acc;
    acc = v && m_ready(sel, rdy);
    for (int i = 0; i < 4; i++)
      if (m_full[i] && rdy[i]) m_full[i] = 1'b0;
    if (acc && sel < 4) begin
      m_full[sel] = 1'b1;
      m_data[sel] = d;
    end
  endfunction

  function automatic logic [31:0] m_outp();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m_full[i]) r[i*8 +: 8] = m_data[i];
    return r;
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_full[i];
    return r;
  endfunction

  task automatic drive4(input logic v, input int sel, input logic [7:0] d, input logic [3:0] rdy);
    in_valid4  = v;
    in_sel4    = 2'(sel);
    in_data4   = d;
    out_ready4 = rdy;
  endtask

  task automatic test_reset();
    drive4(1'b1, 1, 8'hFF, 4'hF);
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h77; out_ready3 = 3'b111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid4 !== 4'h0 || outp4 !== 32'h0) begin
        errors++; $display("FAIL reset_out4: valid=%h outp=%h required 0/0", out_valid4, outp4);
      end
      checks++;
      if (drop_cnt4 !== 8'd0 || drop_cnt3 !== 8'd0) begin
        errors++; $display("FAIL reset_drop: got %0d/%0d required 0/0", drop_cnt4, drop_cnt3);
      end
      checks++;
      if (out_valid3 !== 3'b0 || outp3 !== 24'h0) begin
        errors++; $display("FAIL reset_out3: valid=%b outp=%h required 0/0", out_valid3, outp3);
      end
    end
    @(negedge clk);
    drive4(1'b0, 0, 8'h00, 4'h0);
    in_valid3 = 1'b0;
    rstn = 1'b1;
    m_reset();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (out_valid4 !== 4'h0) begin
        errors++; $display("FAIL post_reset_idle: valid=%h required 0", out_valid4);
      end
      m_step(in_valid4, in_sel4, in_data4, out_ready4);
      @(negedge clk);
    end
  endtask

  task automatic test_single_steer();
    drive4(1'b1, 2, 8'hA5, 4'hF); #1;
    checks++;
    if (in_ready4 !== 1'b1) begin
      errors++; $display("FAIL steer_ready: got %b required 1", in_ready4);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk);
    drive4(1'b0, 0, 8'h00, 4'hF); #1;
    checks++;
    if (out_valid4 !== 4'b0100) begin
      errors++; $display("FAIL steer_valid: got %b required 0100", out_valid4);
    end
    checks++;
    if (outp4 !== 32'h00A5_0000) begin
      errors++; $display("FAIL steer_outp: got %h required 00a50000", outp4);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk); #1;
    checks++;
    if (out_valid4 !== 4'h0 || outp4 !== 32'h0) begin
      errors++; $display("FAIL steer_drain: valid=%h outp=%h required 0/0", out_valid4, outp4);
    end
  endtask

  task automatic test_stall_hol();
    drive4(1'b1, 1, 8'h11, 4'b1101); #1;
    checks++;
    if (in_ready4 !== 1'b1) begin
      errors++; $display("FAIL hol_first_ready: got %b required 1", in_ready4);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk);
    // 8'h22 stalls on FULL ch1 even though ch0 is EMPTY; 8'h33 queues behind it.
    drive4(1'b1, 1, 8'h22, 4'b1101);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready4 !== 1'b0) begin
        errors++; $display("FAIL hol_stall_ready: cycle %0d got %b required 0", c, in_ready4);
      end
      checks++;
      if (out_valid4 !== 4'b0010 || outp4[1] !== 8'h11) begin
        errors++; $display("FAIL hol_hold: valid=%b outp1=%h required 0010/11", out_valid4, outp4[1]);
      end
      m_step(in_valid4, in_sel4, in_data4, out_ready4);
      @(negedge clk);
    end
    drive4(1'b1, 1, 8'h22, 4'b1111); #1;
    checks++;
    if (in_ready4 !== 1'b1) begin
      errors++; $display("FAIL hol_release_ready: got %b required 1", in_ready4);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk);
    drive4(1'b1, 0, 8'h33, 4'b1101); #1;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 4'b0010 || outp4[1] !== 8'h22) begin
      errors++; $display("FAIL hol_second: ready=%b valid=%b outp1=%h required 1/0010/22",
                         in_ready4, out_valid4, outp4[1]);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk);
    drive4(1'b0, 0, 8'h00, 4'b1111); #1;
    checks++;
    if (out_valid4 !== 4'b0011 || outp4 !== 32'h0000_2233) begin
      errors++; $display("FAIL hol_third: valid=%b outp=%h required 0011/00002233", out_valid4, outp4);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) drive4(1'b1, 3, 8'(8'h40 + i), 4'hF);
      else        drive4(1'b0, 0, 8'h00, 4'hF);
      #1;
      if (i < 16) begin
        checks++;
        if (in_ready4 !== 1'b1) begin
          errors++; $display("FAIL b2b_ready: word %0d got %b required 1", i, in_ready4);
        end
      end
      if (i > 0) begin
        checks++;
        if (out_valid4 !== 4'b1000 || outp4[3] !== 8'(8'h40 + i - 1)) begin
          errors++; $display("FAIL b2b_data: word %0d valid=%b outp3=%h required 1000/%h",
                             i - 1, out_valid4, outp4[3], 8'(8'h40 + i - 1));
        end
      end
      m_step(in_valid4, in_sel4, in_data4, out_ready4);
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid4 !== 4'h0) begin
      errors++; $display("FAIL b2b_end: valid=%b required 0000", out_valid4);
    end
  endtask

  task automatic test_out_of_range();
    in_valid3 = 1'b1; in_sel3 = 2'd3; out_ready3 = 3'b111;
    for (int k = 0; k < 300; k++) begin
      in_data3 = 8'($urandom); #1;
      checks++;
      if (in_ready3 !== 1'b1 || out_valid3 !== 3'b000) begin
        errors++; $display("FAIL oor_flow: word %0d ready=%b valid=%b required 1/000", k, in_ready3, out_valid3);
      end
      checks++;
      if (drop_cnt3 !== 8'(m_drop3)) begin
        errors++; $display("FAIL oor_count: word %0d got %0d required %0d", k, drop_cnt3, m_drop3);
      end
      if (m_drop3 < 255) m_drop3++;
      @(negedge clk);
    end
    in_sel3 = 2'd2; in_data3 = 8'h9C; #1;
    checks++;
    if (drop_cnt3 !== 8'd255) begin
      errors++; $display("FAIL oor_saturate: got %0d required 255", drop_cnt3);
    end
    @(negedge clk);
    in_valid3 = 1'b0; #1;
    checks++;
    if (out_valid3 !== 3'b100 || outp3 !== 24'h9C_0000 || drop_cnt3 !== 8'd255) begin
      errors++; $display("FAIL oor_last_channel: valid=%b outp=%h drop=%0d required 100/9c0000/255",
                         out_valid3, outp3, drop_cnt3);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    for (int ch = 0; ch < 4; ch++) begin
      drive4(1'b1, ch, 8'(8'hC0 + ch), 4'h0); #1;
      checks++;
      if (in_ready4 !== 1'b1) begin
        errors++; $display("FAIL areset_fill: ch %0d ready=%b required 1", ch, in_ready4);
      end
      m_step(in_valid4, in_sel4, in_data4, out_ready4);
      @(negedge clk);
    end
    drive4(1'b0, 0, 8'h00, 4'h0); #1;
    checks++;
    if (out_valid4 !== 4'hF || outp4 !== 32'hC3C2_C1C0) begin
      errors++; $display("FAIL areset_full: valid=%b outp=%h required 1111/c3c2c1c0", out_valid4, outp4);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (out_valid4 !== 4'h0 || outp4 !== 32'h0 || drop_cnt4 !== 8'd0) begin
      errors++; $display("FAIL areset_immediate: valid=%b outp=%h drop=%0d required 0/0/0",
                         out_valid4, outp4, drop_cnt4);
    end
    rstn = 1'b1;
    m_reset();
    m_drop3 = 0;
    @(negedge clk);
    drive4(1'b1, 1, 8'h5A, 4'h0); #1;
    checks++;
    if (in_ready4 !== 1'b1) begin
      errors++; $display("FAIL areset_after_ready: got %b required 1", in_ready4);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk);
    drive4(1'b0, 0, 8'h00, 4'hF); #1;
    checks++;
    if (out_valid4 !== 4'b0010 || outp4 !== 32'h0000_5A00) begin
      errors++; $display("FAIL areset_alone: valid=%b outp=%h required 0010/00005a00", out_valid4, outp4);
    end
    m_step(in_valid4, in_sel4, in_data4, out_ready4);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic       v;
    int         sel;
    logic [7:0] d;
    logic [3:0] rdy;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      d   = 8'($urandom);
      rdy = 4'($urandom);
      drive4(v, sel, d, rdy); #1;
      checks++;
      if (in_ready4 !== m_ready(sel, rdy)) begin
        errors++; $display("FAIL rand_ready: cycle %0d got %b required %b", c, in_ready4, m_ready(sel, rdy));
      end
      checks++;
      if (out_valid4 !== m_valid()) begin
        errors++; $display("FAIL rand_valid: cycle %0d got %b required %b", c, out_valid4, m_valid());
      end
      checks++;
      if (outp4 !== m_outp()) begin
        errors++; $display("FAIL rand_outp: cycle %0d got %h required %h", c, outp4, m_outp());
      end
      m_step(v, sel, d, rdy);
      @(negedge clk);
    end
    #1;
    checks++;
    if (drop_cnt4 !== 8'd0) begin
      errors++; $display("FAIL rand_drop: got %0d required 0", drop_cnt4);
    end
  endtask

  initial begin
    rstn = 1'b1;
    drive4(1'b0, 0, 8'h00, 4'h0);
    in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = 8'h00; out_ready3 = 3'b000;
    m_reset();
    #1 rstn = 1'b0;
    test_reset();
    test_single_steer();
    test_stall_hol();
    test_back_to_back();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
